// File: rtl/scr1_wb_sram_responder.sv
// scr1_wb_sram_responder: Wishbone slave fronting a 1-cycle-latency single-port SRAM,
// with programmable ack stall, out-of-window error response and transfer/error counters.
module scr1_wb_sram_responder #(
    parameter int                       SCR1_WB_WIDTH = 32,
    parameter int                       MEM_AW        = 10,
    parameter logic [SCR1_WB_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic                     wbd_stb_i,
    input  logic [SCR1_WB_WIDTH-1:0] wbd_adr_i,
    input  logic                     wbd_we_i,
    input  logic [SCR1_WB_WIDTH-1:0] wbd_dat_i,
    input  logic [3:0]               wbd_sel_i,
    output logic [SCR1_WB_WIDTH-1:0] wbd_dat_o,
    output logic                     wbd_ack_o,
    output logic                     wbd_err_o,
    input  logic [3:0]               stall_cfg_i,
    output logic                     mem_cs_o,
    output logic                     mem_we_o,
    output logic [MEM_AW-1:0]        mem_addr_o,
    output logic [3:0]               mem_wmask_o,
    output logic [SCR1_WB_WIDTH-1:0] mem_wdata_o,
    input  logic [SCR1_WB_WIDTH-1:0] mem_rdata_i,
    output logic [15:0]              xfer_cnt_o,
    output logic [7:0]               err_cnt_o
);
    typedef enum logic [2:0] {IDLE, STALL, ACC, RDAT, ACK, ERR} state_t;
    state_t                     r_state;
    logic [MEM_AW-1:0]          r_idx;
    logic                       r_we;
    logic [SCR1_WB_WIDTH-1:0]   r_dat;
    logic [3:0]                 r_sel;
    logic [3:0]                 r_cnt;
    logic [MEM_AW-1:0]          w_idx;
    logic                       w_we;
    logic [SCR1_WB_WIDTH-1:0]   w_dat;
    logic [3:0]                 w_sel;
    logic                       w_hit;
    logic                       w_go_acc;
    logic                       w_unused;
    // Entering ACC straight from IDLE must use the bus inputs, not yet latched.
    always_comb begin
        w_idx    = r_state == IDLE ? wbd_adr_i[MEM_AW+1:2] : r_idx;
        w_we     = r_state == IDLE ? wbd_we_i : r_we;
        w_dat    = r_state == IDLE ? wbd_dat_i : r_dat;
        w_sel    = r_state == IDLE ? wbd_sel_i : r_sel;
        w_hit    = wbd_adr_i[SCR1_WB_WIDTH-1:MEM_AW+2] == BASE_ADDR[SCR1_WB_WIDTH-1:MEM_AW+2];
        w_go_acc = (r_state == IDLE && wbd_stb_i && w_hit && stall_cfg_i == 4'd0) ||
                   (r_state == STALL && r_cnt == 4'd1);
    end
    assign w_unused = &{1'b0, wbd_adr_i[1:0]};
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            wbd_dat_o   <= '0;
            wbd_ack_o   <= 1'b0;
            wbd_err_o   <= 1'b0;
            mem_cs_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wmask_o <= '0;
            mem_wdata_o <= '0;
            xfer_cnt_o  <= '0;
            err_cnt_o   <= '0;
        end else begin
            wbd_ack_o   <= 1'b0;
            wbd_err_o   <= 1'b0;
            mem_cs_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wmask_o <= '0;
            mem_wdata_o <= '0;
            if (w_go_acc) begin
                r_state <= ACC;
                if (!w_we || w_sel != 4'd0) begin
                    mem_cs_o    <= 1'b1;
                    mem_we_o    <= w_we;
                    mem_addr_o  <= w_idx;
                    mem_wmask_o <= w_sel;
                    mem_wdata_o <= w_dat;
                end
            end
            case (r_state)
                IDLE: if (wbd_stb_i) begin
                    r_idx <= wbd_adr_i[MEM_AW+1:2];
                    r_we  <= wbd_we_i;
                    r_dat <= wbd_dat_i;
                    r_sel <= wbd_sel_i;
                    r_cnt <= stall_cfg_i;
                    if (!w_hit) begin
                        r_state   <= ERR;
                        wbd_err_o <= 1'b1;
                        err_cnt_o <= err_cnt_o == 8'hFF ? err_cnt_o : err_cnt_o + 8'd1;
                    end else if (stall_cfg_i != 4'd0) begin
                        r_state <= STALL;
                    end
                end
                STALL: r_cnt <= r_cnt - 4'd1;
                ACC: begin
                    r_state    <= r_we ? ACK : RDAT;
                    wbd_ack_o  <= r_we;
                    xfer_cnt_o <= r_we ? xfer_cnt_o + 16'd1 : xfer_cnt_o;
                end
                RDAT: begin
                    wbd_dat_o  <= mem_rdata_i;
                    r_state    <= ACK;
                    wbd_ack_o  <= 1'b1;
                    xfer_cnt_o <= xfer_cnt_o + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scr1_wb_sram_responder.sv
// tb_scr1_wb_sram_responder: randomized scoreboard bench with a word-array memory model.
module tb_scr1_wb_sram_responder;
    logic        clk = 1'b0, rst = 1'b1, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0, stall = '0;
    logic [31:0] dat_o, mwdata, mrdata;
    logic        ack, err, cs, mwe;
    logic [9:0]  maddr;
    logic [3:0]  mmask;
    logic [15:0] xc;
    logic [7:0]  ec;

    scr1_wb_sram_responder dut (
        .wb_clk(clk), .wb_rst(rst), .wbd_stb_i(stb), .wbd_adr_i(adr), .wbd_we_i(we),
        .wbd_dat_i(dat), .wbd_sel_i(sel), .wbd_dat_o(dat_o), .wbd_ack_o(ack), .wbd_err_o(err),
        .stall_cfg_i(stall), .mem_cs_o(cs), .mem_we_o(mwe), .mem_addr_o(maddr),
        .mem_wmask_o(mmask), .mem_wdata_o(mwdata), .mem_rdata_i(mrdata),
        .xfer_cnt_o(xc), .err_cnt_o(ec)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic [31:0] sram [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] last_rd = '0;
    logic [15:0] ref_xc = '0;
    logic [7:0]  ref_ec = '0;
    logic [31:0] sram_tmp;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [31:0] dat;
        logic [15:0] xc;
        logic [7:0]  ec;
    } exp_t;
    exp_t q[$];

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // SRAM macro: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (cs) begin
            if (mwe) begin
                sram_tmp = sram[maddr];
                for (int b = 0; b < 4; b++)
                    if (mmask[b]) sram_tmp[8*b +: 8] = mwdata[8*b +: 8];
                sram[maddr] <= sram_tmp;
            end else begin
                mrdata <= sram[maddr];
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ack && err) chk(1'b0, "ack_err_overlap", {ack, err}, 0);
            if (ack || err) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_resp", {ack, err}, 0);
                end else begin
                    e = q.pop_front();
                    chk(err == e.is_err, "resp_kind_err", err, e.is_err);
                    chk(cyc == e.cyc, "resp_cycle", cyc, e.cyc);
                    chk(dat_o == e.dat, "dat_o", dat_o, e.dat);
                    chk(xc == e.xc, "xfer_cnt", xc, e.xc);
                    chk(ec == e.ec, "err_cnt", ec, e.ec);
                end
            end
            if (!cs) chk(!mwe && maddr == 0 && mmask == 0 && mwdata == 0, "mem_idle_zero",
                         {mwe, mmask, maddr} ^ mwdata, 0);
        end
    end

    task automatic xfer(input logic [31:0] ta, input logic twe, input logic [31:0] td,
                        input logic [3:0] ts, input logic [3:0] tst, input int drop_after);
        int   n, lat, cs_seen;
        bit   inwin, done, cs_exp;
        exp_t e;
        int   idx;
        @(negedge clk);
        stb = 1'b1; adr = ta; we = twe; dat = td; sel = ts; stall = tst;
        @(posedge clk);
        #1 n = cyc;
        inwin = ta[31:12] == 20'h0;
        idx = int'(ta[11:2]);
        if (!inwin) begin
            lat = 0;
            ref_ec = ref_ec == 8'hFF ? ref_ec : ref_ec + 8'd1;
        end else begin
            lat = twe ? 1 + int'(tst) : 2 + int'(tst);
            ref_xc = ref_xc + 16'd1;
            if (twe) begin
                for (int b = 0; b < 4; b++)
                    if (ts[b]) ref_mem[idx][8*b +: 8] = td[8*b +: 8];
            end else begin
                last_rd = ref_mem[idx];
            end
        end
        e.is_err = !inwin; e.cyc = n + lat; e.dat = last_rd; e.xc = ref_xc; e.ec = ref_ec;
        q.push_back(e);
        cs_exp = inwin && !(twe && ts == 4'd0);
        adr = $urandom; we = 1'($urandom); dat = $urandom; sel = 4'($urandom); stall = 4'($urandom);
        cs_seen = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (cs) begin
                cs_seen++;
                chk(cyc == n + int'(tst), "acc_cycle", cyc, n + int'(tst));
                chk(maddr == ta[11:2], "mem_addr", maddr, ta[11:2]);
                chk(mmask == ts, "mem_wmask", mmask, ts);
                chk(mwe == twe, "mem_we", mwe, twe);
                chk(mwdata == td, "mem_wdata", mwdata, td);
            end
            if (ack || err) done = 1'b1;
            if (k == drop_after) stb = 1'b0;
        end
        stb = 1'b0;
        chk(done, "resp_timeout", done, 1);
        chk(cs_seen == int'(cs_exp), "mem_cs_count", cs_seen, cs_exp);
    endtask

    task automatic rst_mid(input logic [31:0] ta, input logic twe, input logic [31:0] td,
                           input logic [3:0] tst, input int k_rst);
        @(negedge clk);
        stb = 1'b1; adr = ta; we = twe; dat = td; sel = 4'hF; stall = tst;
        @(posedge clk);
        for (int k = 0; k <= k_rst; k++) begin
            @(negedge clk);
            chk(!ack && !err, "no_resp_before_rst", {ack, err}, 0);
            if (twe) chk(!cs, "no_cs_before_rst", cs, 0);
        end
        rst = 1'b1; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk(dat_o == 0 && !ack && !err, "rst_bus_zero", dat_o ^ {ack, err}, 0);
        chk(!cs && !mwe && maddr == 0 && mmask == 0 && mwdata == 0, "rst_mem_zero", {cs, mwe, mmask}, 0);
        chk(xc == 0 && ec == 0, "rst_cnt_zero", {xc, ec}, 0);
        ref_xc = '0; ref_ec = '0; last_rd = '0;
        repeat (3) begin
            @(negedge clk);
            chk(!ack && !err && !cs, "quiet_after_rst", {ack, err, cs}, 0);
        end
    endtask

    initial begin
        logic [3:0] sweep [4];
        logic [31:0] ra;
        sweep = '{4'd0, 4'd1, 4'd7, 4'd15};
        for (int i = 0; i < 1024; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(dat_o == 0 && !ack && !err, "reset_bus", dat_o ^ {ack, err}, 0);
        chk(!cs && !mwe && maddr == 0 && mmask == 0 && mwdata == 0, "reset_mem", {cs, mwe, mmask}, 0);
        chk(xc == 0, "reset_xfer_cnt", xc, 0);
        chk(ec == 0, "reset_err_cnt", ec, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk(!cs && !ack && !err, "idle_quiet", {cs, ack, err}, 0);
        end

        xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'd0, -1);
        xfer(32'h10, 1'b0, 32'h0, 4'hF, 4'd0, -1);
        chk(dat_o == 32'hDEAD_BEEF, "read_deadbeef", dat_o, 32'hDEAD_BEEF);
        chk(xc == 16'd2, "xfer_cnt_two", xc, 2);
        xfer(32'h10, 1'b1, 32'h0000_5500, 4'b0010, 4'd0, -1);
        xfer(32'h12, 1'b0, 32'h0, 4'hF, 4'd0, -1);
        chk(dat_o == 32'hDEAD_55EF, "byte_merge", dat_o, 32'hDEAD_55EF);
        foreach (sweep[i]) xfer(32'h10, 1'b0, 32'h0, 4'hF, sweep[i], -1);
        xfer(32'h10, 1'b1, 32'h1234_5678, 4'h0, 4'd2, -1);
        xfer(32'h10, 1'b0, 32'h0, 4'hF, 4'd3, -1);
        chk(dat_o == 32'hDEAD_55EF, "sel0_no_write", dat_o, 32'hDEAD_55EF);

        for (int i = 0; i < 300; i++) xfer(32'h1000, 1'($urandom), $urandom, 4'hF, 4'($urandom), -1);
        chk(ec == 8'hFF, "err_cnt_saturated", ec, 8'hFF);
        chk(xc == ref_xc, "xfer_cnt_after_errs", xc, ref_xc);

        xfer(32'h20, 1'b1, 32'h1111_2222, 4'hF, 4'd0, -1);
        rst_mid(32'h20, 1'b1, 32'hCAFE_F00D, 4'd10, 3);
        xfer(32'h20, 1'b0, 32'h0, 4'hF, 4'd0, -1);
        chk(dat_o == 32'h1111_2222, "stall_rst_no_write", dat_o, 32'h1111_2222);
        rst_mid(32'h20, 1'b0, 32'h0, 4'd0, 0);

        xfer(32'h24, 1'b1, 32'hA5A5_5A5A, 4'hF, 4'd5, 1);
        xfer(32'h24, 1'b0, 32'h0, 4'hF, 4'd0, -1);
        chk(dat_o == 32'hA5A5_5A5A, "stb_drop_written", dat_o, 32'hA5A5_5A5A);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom_range(0, 99) < 85 ? 32'($urandom_range(0, 63)) : ($urandom | 32'h1000);
            xfer(ra, 1'($urandom), $urandom, 4'($urandom), 4'($urandom_range(0, 4)), -1);
        end

        repeat (5) @(negedge clk);
        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scr1_wb_sram_responder.md
# scr1_wb_sram_responder

Synthesizable Wishbone responder that terminates one SCR1 `wbd_imem_*` or `wbd_dmem_*` initiator port. It drives a single-port synchronous SRAM macro with one-cycle read latency. It adds programmable ack-stall injection, out-of-window error response, and transfer/error counters. It replaces behavioural memory on the FPGA/ASIC build and serves as a reusable on-chip instruction or data RAM slave.

## Interface
- `SCR1_WB_WIDTH`, 32: data and address width.
- `MEM_AW`, 10: SRAM word-address bits (4 KB window).
- `BASE_ADDR`, 32'h0000_0000: window base; bits [MEM_AW+1:0] ignored.
- `wb_clk`  in  1  sole clock; all logic on posedge.
- `wb_rst`  in  1  synchronous, active-high reset.
- `wbd_stb_i`  in  1  request strobe, held by initiator until ack/err.
- `wbd_adr_i`  in  32  byte address.
- `wbd_we_i`  in  1  1 = write.
- `wbd_dat_i`  in  32  write data.
- `wbd_sel_i`  in  4  byte enables.
- `wbd_dat_o`  out  32  read data, registered.
- `wbd_ack_o`  out  1  one-cycle completion pulse.
- `wbd_err_o`  out  1  one-cycle error pulse.
- `stall_cfg_i`  in  4  extra wait cycles per in-window transfer.
- `mem_cs_o`, `mem_we_o`  out  1  SRAM select / write.
- `mem_addr_o`  out  MEM_AW  SRAM word address.
- `mem_wmask_o`  out  4  byte write mask.
- `mem_wdata_o`  out  32  SRAM write data.
- `mem_rdata_i`  in  32  SRAM read data, valid the cycle after `mem_cs_o & ~mem_we_o`.
- `xfer_cnt_o`  out  16  completed acks, wraps.
- `err_cnt_o`  out  8  error responses, saturates at 8'hFF.

## Operation
- FSM states: IDLE, STALL, ACC, RDAT, ACK, ERR.
- IDLE with `wbd_stb_i`=1:
  - Latch adr/we/dat/sel/stall_cfg.
  - In window (`adr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]`): go to STALL if stall≠0, else ACC.
  - Out of window: go to ERR; no stall is applied and no SRAM access is made.
- STALL: decrement latched count; go to ACC when count reaches 1.
- ACC:
  - `mem_cs_o`=1 for exactly one cycle.
  - `mem_addr_o` = adr[MEM_AW+1:2], `mem_we_o` = we, `mem_wmask_o` = sel, `mem_wdata_o` = dat.
  - Write goes to ACK; read goes to RDAT.
  - Write with sel=4'b0000: `mem_cs_o` stays 0 and the transfer still acks.
- RDAT: capture `mem_rdata_i` into the `wbd_dat_o` register, then go to ACK.
- ACK: `wbd_ack_o`=1, `xfer_cnt_o`++, then go to IDLE.
- ERR: `wbd_err_o`=1, `err_cnt_o`++ (saturating), then go to IDLE.
- adr[1:0] is ignored. Reads always return the full word; the initiator selects bytes.
- Bus inputs are ignored after latching. If `wbd_stb_i` drops mid-transfer, the transfer still completes (SRAM write committed, ack pulsed) and the initiator discards it.
- `wbd_dat_o` holds its last read value through writes and errors.
- All mem_* outputs are 0 outside ACC.

## Timing
- Reset (any state, any cycle) → IDLE next edge.
  - All outputs are 0, including `wbd_dat_o`, both counters and all mem_*.
  - A transfer in STALL is abandoned with no SRAM write.
  - An SRAM access issued in the same cycle as reset is not acknowledged.
- Let stb be sampled in IDLE at edge N, with S = latched stall:
  - ACC occupies cycle N+1+S.
  - Write: ack in cycle N+2+S.
  - Read: `wbd_dat_o` valid and ack in cycle N+3+S.
  - Error: err in cycle N+1.
- Back-to-back: the cycle after ACK/ERR is IDLE and samples stb. Stb still high there is a new transfer, so the minimum period is 3 cycles for writes and 4 cycles for reads.
- ack and err are never asserted together; each is at most one cycle per accepted strobe.
- `xfer_cnt_o` wraps 16'hFFFF→0. `err_cnt_o` holds at 8'hFF.

## Test plan
- Reset then idle: `wb_rst`=1 for 2 cycles → all outputs 0; `xfer_cnt_o`=0; stb=0 produces no mem_cs.
- Write 32'hDEAD_BEEF to 0x0000_0010 with sel=4'hF and stall=0, then read the same address:
  - `mem_cs_o` on cycle N+1 with `mem_addr_o`=4 and mask F; write ack on cycle N+2.
  - Read ack on N+3 with `wbd_dat_o`=DEADBEEF.
  - `xfer_cnt_o`=2.
- Byte write 32'h0000_5500 with sel=4'b0010 over existing DEADBEEF, then read → `mem_wmask_o`=0010 during ACC; read returns DEAD55EF.
- Stall sweep: stall_cfg=0,1,7,15 on reads → ack at exactly N+3+S each time. Changing stall_cfg mid-transfer has no effect.
- Out-of-window access to 0x0000_1000 with MEM_AW=10 → err on N+1, no mem_cs. After 300 such errors `err_cnt_o`=8'hFF; `xfer_cnt_o` is unchanged.
- Mid-transfer boundaries:
  - Assert `wb_rst` during STALL of a write → no ack, no mem_cs; a later read shows the old data.
  - Deassert stb during STALL of a write → ack still pulses and the data is written.
